ceespu_regfile_mp: RTL and testbench
====================================

// Module: ceespu_regfile_mp
// PURPOSE
//  Parametrised multi-read-port register file for the ceespu core, replacing the fixed 32x32 2-read file.
//  Register count, width and read-port count are configurable; a hardware init sequencer loads reset contents.
//  Software can also re-initialise the file via I_clear. Sits between decode (read selects) and writeback (write port).
// PARAMETERS
//  DATA_W   32            register width in bits
//  ADDR_W   5             select width; DEPTH = 2**ADDR_W registers
//  NUM_RD   2             number of independent combinational read ports (1..4)
//  SP_IDX   18            index loaded with SP_INIT by the init sequence (stack pointer)
//  SP_INIT  32'h0000fff0  init value of register SP_IDX; every other register inits to 0
//  R0_ZERO  0             1: register 0 always reads 0 and ignores writes
// PORTS
//  I_clk    in   1                clock, all state on rising edge
//  I_rst    in   1                reset, asynchronous, active-low
//  I_sel    in   NUM_RD*ADDR_W    read selects, port p at [p*ADDR_W +: ADDR_W]
//  O_data   out  NUM_RD*DATA_W    read data, port p at [p*DATA_W +: DATA_W]
//  I_we     in   1                write enable
//  I_selD   in   ADDR_W           write select
//  I_dataD  in   DATA_W           write data
//  I_clear  in   1                request re-initialisation (single-cycle pulse or level)
//  O_ready  out  1                1 = file initialised, writes accepted, reads valid
// BEHAVIOUR
//  - FSM states: S_INIT, S_READY. I_rst low -> S_INIT, sweep index idx=0, O_ready=0 (async).
//  - S_INIT: each cycle writes init value to regfile[idx] (SP_INIT if idx==SP_IDX, else 0), idx++.
//    On the cycle idx==DEPTH-1 is written -> S_READY next edge; O_ready=1 from that edge. Init takes DEPTH cycles.
//  - S_INIT: I_we ignored (write dropped, not queued); I_clear ignored; all O_data forced to 0.
//  - S_READY: I_clear=1 at an edge -> S_INIT, idx=0; that edge performs no user write even if I_we=1.
//  - S_READY write: I_we=1 -> regfile[I_selD] <= I_dataD at rising edge. R0_ZERO=1 and I_selD==0 -> dropped.
//  - Reads: O_data[p] = regfile[I_sel[p]], purely combinational, zero latency; R0_ZERO=1 and sel==0 -> 0.
//  - Read-during-write (same index, same cycle) without bypass: old value until edge, new value after.
//  - All read ports independent; identical selects on several ports return identical data.
//  - Reset mid-init or mid-operation: restarts sweep at idx=0; contents undefined until init completes.
//  - idx is ADDR_W+1 bits wide internally so DEPTH-1 terminal compare never wraps.
// CONFIGURATION
//  CEESPU_REGFILE_BYPASS_EN defined: in S_READY, if I_we=1 and I_sel[p]==I_selD (and write not dropped
//    by R0_ZERO), O_data[p] = I_dataD in the same cycle (write-through forwarding).
//  Not defined: no forwarding; read-during-write returns the pre-write value as above.
// STRUCTURE
//  - ceespu_pkg: state enum (S_INIT, S_READY), default DATA_W/ADDR_W constants, SP_IDX/SP_INIT defaults.
//  - Sub-module ceespu_regfile_init_seq: FSM + idx counter; outputs init_we, init_addr, init_data, ready.
//  - Top muxes init vs user write port into the storage array; read ports generated per NUM_RD.
// TESTING
//  - Reset release -> O_ready=0 for exactly 32 cycles (ADDR_W=5), then 1; reg18 reads 0x0000fff0, reg5 reads 0.
//  - S_READY, write r7=0xDEADBEEF -> next cycle both ports sel=7 read 0xDEADBEEF.
//  - Same-cycle write r3=0x1234 with port0 sel=3: bypass build reads 0x1234 that cycle; non-bypass reads 0.
//  - I_we=1 r9=0x55 during S_INIT -> after init r9 reads 0; I_clear in S_READY -> r7 back to 0 after 32 cycles.
//  - R0_ZERO=1: write r0=0xFFFFFFFF -> r0 reads 0; bypass build also reads 0 same cycle.
//  - Assert I_rst low at init idx=10 -> O_ready stays 0, sweep restarts, ready after full 32 cycles.

Source files
------------

// File: rtl/ceespu_pkg.sv
// ceespu_pkg
//   Shared definitions for the ceespu register file:
//   - regfile_state_t : init-sequencer states (S_INIT sweeps reset contents, S_READY serves the core)
//   - default geometry (DATA_W_DEF, ADDR_W_DEF) and stack-pointer init defaults (SP_IDX_DEF, SP_INIT_DEF)
package ceespu_pkg;

    typedef enum logic [0:0] {
        S_INIT  = 1'b0,
        S_READY = 1'b1
    } regfile_state_t;

    localparam int          DATA_W_DEF  = 32;
    localparam int          ADDR_W_DEF  = 5;
    localparam int          SP_IDX_DEF  = 18;
    localparam logic [31:0] SP_INIT_DEF = 32'h0000fff0;

endpackage

// File: rtl/ceespu_regfile_init_seq.sv
// ceespu_regfile_init_seq
//   Init sequencer for the register file. After reset (or a clear request while
//   ready) it sweeps every index once, presenting one init write per cycle, then
//   reports ready.
// Ports
//   I_clk      in   clock, rising edge
//   I_rst      in   asynchronous active-low reset
//   clear      in   re-initialisation request, honoured only in S_READY
//   init_we    out  init write strobe (high for the whole sweep)
//   init_addr  out  index being initialised
//   init_data  out  init value for init_addr (SP_INIT at SP_IDX, else 0)
//   ready      out  registered: file initialised
module ceespu_regfile_init_seq
    import ceespu_pkg::*;
#(
    parameter int                ADDR_W  = ADDR_W_DEF,
    parameter int                DATA_W  = DATA_W_DEF,
    parameter int                SP_IDX  = SP_IDX_DEF,
    parameter logic [DATA_W-1:0] SP_INIT = SP_INIT_DEF
) (
    input  logic              I_clk,
    input  logic              I_rst,
    input  logic              clear,
    output logic              init_we,
    output logic [ADDR_W-1:0] init_addr,
    output logic [DATA_W-1:0] init_data,
    output logic              ready
);

    localparam int DEPTH = 2 ** ADDR_W;
    // One extra index bit keeps the terminal compare clear of wrap-around.
    localparam logic [ADDR_W:0] LAST_IDX  = (ADDR_W + 1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] SP_IDX_W  = (ADDR_W + 1)'(SP_IDX);
    localparam logic [ADDR_W:0] IDX_ZERO  = {(ADDR_W + 1){1'b0}};
    localparam logic [ADDR_W:0] IDX_ONE   = {{ADDR_W{1'b0}}, 1'b1};

    regfile_state_t    state_r;
    regfile_state_t    state_next_s;
    logic [ADDR_W:0]   idx_r;
    logic [ADDR_W:0]   idx_next_s;
    logic              ready_r;
    logic              init_we_s;
    logic [DATA_W-1:0] init_data_s;

    // State, sweep index and ready flag registers
    always_ff @(posedge I_clk or negedge I_rst) begin
        if (!I_rst) begin
            state_r <= S_INIT;
            idx_r   <= IDX_ZERO;
            ready_r <= 1'b0;
        end else begin
            state_r <= state_next_s;
            idx_r   <= idx_next_s;
            ready_r <= (state_next_s == S_READY);
        end
    end

    // Next-state and next-index logic
    always_comb begin
        state_next_s = state_r;
        idx_next_s   = idx_r;
        case (state_r)
            S_INIT: begin
                if (idx_r == LAST_IDX) begin
                    state_next_s = S_READY;
                    idx_next_s   = IDX_ZERO;
                end else begin
                    state_next_s = S_INIT;
                    idx_next_s   = idx_r + IDX_ONE;
                end
            end
            S_READY: begin
                if (clear) begin
                    state_next_s = S_INIT;
                    idx_next_s   = IDX_ZERO;
                end else begin
                    state_next_s = S_READY;
                    idx_next_s   = idx_r;
                end
            end
            default: begin
                state_next_s = S_INIT;
                idx_next_s   = IDX_ZERO;
            end
        endcase
    end

    // Init write port driven from the current state
    always_comb begin
        init_we_s   = 1'b0;
        init_data_s = {DATA_W{1'b0}};
        case (state_r)
            S_INIT: begin
                init_we_s = 1'b1;
                if (idx_r == SP_IDX_W) begin
                    init_data_s = SP_INIT;
                end else begin
                    init_data_s = {DATA_W{1'b0}};
                end
            end
            S_READY: begin
                init_we_s   = 1'b0;
                init_data_s = {DATA_W{1'b0}};
            end
            default: begin
                init_we_s   = 1'b0;
                init_data_s = {DATA_W{1'b0}};
            end
        endcase
    end

    assign init_we   = init_we_s;
    assign init_addr = idx_r[ADDR_W-1:0];
    assign init_data = init_data_s;
    assign ready     = ready_r;

endmodule

// File: rtl/ceespu_regfile_mp.sv
// ceespu_regfile_mp
//   Parametrised multi-read-port register file for the ceespu core. Contents are
//   loaded by a hardware init sweep after reset or after I_clear; reads are
//   combinational and return 0 until the sweep completes.
//   Optional macro CEESPU_REGFILE_BYPASS_EN: forwards the accepted write data to
//   any read port selecting the written index in the same cycle.
// Ports
//   I_clk    in   clock, rising edge
//   I_rst    in   asynchronous active-low reset
//   I_sel    in   NUM_RD read selects, port p at [p*ADDR_W +: ADDR_W]
//   O_data   out  NUM_RD read data, port p at [p*DATA_W +: DATA_W]
//   I_we     in   write enable (ignored while initialising)
//   I_selD   in   write select
//   I_dataD  in   write data
//   I_clear  in   re-initialisation request (ignored while initialising)
//   O_ready  out  file initialised, writes accepted, reads valid
module ceespu_regfile_mp
    import ceespu_pkg::*;
#(
    parameter int                DATA_W  = DATA_W_DEF,
    parameter int                ADDR_W  = ADDR_W_DEF,
    parameter int                NUM_RD  = 2,
    parameter int                SP_IDX  = SP_IDX_DEF,
    parameter logic [DATA_W-1:0] SP_INIT = SP_INIT_DEF,
    parameter int                R0_ZERO = 0
) (
    input  logic                     I_clk,
    input  logic                     I_rst,
    input  logic [NUM_RD*ADDR_W-1:0] I_sel,
    output logic [NUM_RD*DATA_W-1:0] O_data,
    input  logic                     I_we,
    input  logic [ADDR_W-1:0]        I_selD,
    input  logic [DATA_W-1:0]        I_dataD,
    input  logic                     I_clear,
    output logic                     O_ready
);

    localparam int              DEPTH     = 2 ** ADDR_W;
    localparam bit              R0_ZERO_B = (R0_ZERO != 0);
    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};

    logic [DATA_W-1:0] regs_r [DEPTH];
    logic              init_we_s;
    logic [ADDR_W-1:0] init_addr_s;
    logic [DATA_W-1:0] init_data_s;
    logic              ready_s;
    logic              user_wr_s;
    logic              wr_en_s;
    logic [ADDR_W-1:0] wr_addr_s;
    logic [DATA_W-1:0] wr_data_s;

    ceespu_regfile_init_seq #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .SP_IDX  (SP_IDX),
        .SP_INIT (SP_INIT)
    ) u_init_seq (
        .I_clk     (I_clk),
        .I_rst     (I_rst),
        .clear     (I_clear),
        .init_we   (init_we_s),
        .init_addr (init_addr_s),
        .init_data (init_data_s),
        .ready     (ready_s)
    );

    // A user write lands only when ready, not on a clear edge, and not to a hardwired r0.
    assign user_wr_s = ready_s && I_we && !I_clear && !(R0_ZERO_B && (I_selD == ADDR_ZERO));

    // Single storage write port: init sweep has priority (the two never overlap)
    always_comb begin
        wr_en_s   = 1'b0;
        wr_addr_s = I_selD;
        wr_data_s = I_dataD;
        if (init_we_s) begin
            wr_en_s   = 1'b1;
            wr_addr_s = init_addr_s;
            wr_data_s = init_data_s;
        end else if (user_wr_s) begin
            wr_en_s   = 1'b1;
            wr_addr_s = I_selD;
            wr_data_s = I_dataD;
        end else begin
            wr_en_s   = 1'b0;
        end
    end

    // Storage array write; contents are defined by the init sweep, not by reset
    always_ff @(posedge I_clk) begin
        if (wr_en_s) begin
            regs_r[wr_addr_s] <= wr_data_s;
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [ADDR_W-1:0] sel_s;
        logic              hit_s;
        logic [DATA_W-1:0] rd_data_s;

        assign sel_s = I_sel[p*ADDR_W +: ADDR_W];

`ifdef CEESPU_REGFILE_BYPASS_EN
        assign hit_s = user_wr_s && (sel_s == I_selD);
`else
        assign hit_s = 1'b0;
`endif

        // Read port mux: zero while initialising or for hardwired r0, else forwarded or stored data
        always_comb begin
            rd_data_s = {DATA_W{1'b0}};
            if (!ready_s) begin
                rd_data_s = {DATA_W{1'b0}};
            end else if (R0_ZERO_B && (sel_s == ADDR_ZERO)) begin
                rd_data_s = {DATA_W{1'b0}};
            end else if (hit_s) begin
                rd_data_s = I_dataD;
            end else begin
                rd_data_s = regs_r[sel_s];
            end
        end

        assign O_data[p*DATA_W +: DATA_W] = rd_data_s;
    end

    assign O_ready = ready_s;

endmodule

// File: tb/tb_ceespu_regfile_mp.sv
module tb_ceespu_regfile_mp;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NR    = 2;
    localparam int DEPTH = 32;
`ifdef CEESPU_REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic             I_clk = 1'b0;
    logic             I_rst;
    logic [NR*AW-1:0] I_sel;
    logic [NR*DW-1:0] O_data;
    logic [NR*DW-1:0] O_data_z;
    logic             I_we;
    logic [AW-1:0]    I_selD;
    logic [DW-1:0]    I_dataD;
    logic             I_clear;
    logic             O_ready;
    logic             O_ready_z;

    int vectors = 0;
    int miscompares = 0;

    logic [DW-1:0] model_mem [DEPTH];
    bit            model_ready = 1'b0;

    always #5 I_clk = ~I_clk;

    ceespu_regfile_mp #(.R0_ZERO(0)) dut (
        .I_clk(I_clk), .I_rst(I_rst), .I_sel(I_sel), .O_data(O_data),
        .I_we(I_we), .I_selD(I_selD), .I_dataD(I_dataD),
        .I_clear(I_clear), .O_ready(O_ready)
    );

    ceespu_regfile_mp #(.R0_ZERO(1)) dut_z (
        .I_clk(I_clk), .I_rst(I_rst), .I_sel(I_sel), .O_data(O_data_z),
        .I_we(I_we), .I_selD(I_selD), .I_dataD(I_dataD),
        .I_clear(I_clear), .O_ready(O_ready_z)
    );

    // Reference: what a read of 'sel' must return right now.
    function automatic logic [DW-1:0] exp_read(input int sel, input bit zr0);
        if (!model_ready) return 32'h0;
        if (zr0 && sel == 0) return 32'h0;
        if (BYP && I_we && !I_clear && sel == int'(I_selD)) return I_dataD;
        return model_mem[sel];
    endfunction

    function automatic void model_init();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;
        model_mem[18] = 32'h0000fff0;
        model_ready = 1'b1;
    endfunction

    // Advance one clock; the model applies the edge with the inputs held across it.
    task automatic step();
        @(posedge I_clk);
        if (model_ready && I_rst) begin
            if (I_clear) model_ready = 1'b0;
            else if (I_we) model_mem[I_selD] = I_dataD;
        end
        #1;
    endtask

    task automatic set_sel(input int s0, input int s1);
        I_sel[0*AW +: AW] = AW'(s0);
        I_sel[1*AW +: AW] = AW'(s1);
    endtask

    task automatic test_reset();
        int n;
        logic [DW-1:0] exp;
        I_rst = 1'b1; I_we = 1'b0; I_clear = 1'b0; I_selD = '0; I_dataD = '0;
        set_sel(18, 5);
        step();
        I_rst = 1'b0;
        model_ready = 1'b0;
        #1;
        vectors++;
        if (O_ready !== 1'b0 || O_ready_z !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ready_async: got %b/%b, expected 0", O_ready, O_ready_z);
        end
        step(); step();
        vectors++;
        if (O_data !== '0) begin
            miscompares++;
            $display("FAIL reset_data: got %h, expected 0", O_data);
        end
        I_rst = 1'b1;
        n = 0;
        while (O_ready !== 1'b1 && n < 64) begin step(); n++; end
        vectors++;
        if (n != 32 || O_ready_z !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_init_len: got %0d cycles (z ready %b), expected 32", n, O_ready_z);
        end
        model_init();
        for (int k = 0; k < 2; k++) begin
            if (k == 1) set_sel(0, 18);
            #1;
            for (int p = 0; p < NR; p++) begin
                exp = exp_read(int'(I_sel[p*AW +: AW]), 1'b0);
                vectors++;
                if (O_data[p*DW +: DW] !== exp) begin
                    miscompares++;
                    $display("FAIL reset_contents p%0d sel=%0d: got %h, expected %h", p, I_sel[p*AW +: AW], O_data[p*DW +: DW], exp);
                end
            end
        end
    endtask

    task automatic test_write_read();
        logic [DW-1:0] exp;
        int s;
        for (int it = 0; it < 204; it++) begin
            if (it == 0) begin
                I_we = 1'b1; I_selD = 5'd7; I_dataD = 32'hDEADBEEF; set_sel(7, 7);
            end else if (it == 1) begin
                I_we = 1'b0; set_sel(7, 7);
            end else if (it == 2) begin
                I_we = 1'b1; I_selD = 5'd3; I_dataD = 32'h00001234; set_sel(3, 18);
            end else if (it == 3) begin
                I_we = 1'b0; set_sel(3, 3);
            end else begin
                I_we = ($urandom_range(0, 2) != 0);
                I_selD = AW'($urandom_range(0, DEPTH - 1));
                I_dataD = $urandom;
                for (int p = 0; p < NR; p++) begin
                    s = $urandom_range(0, DEPTH - 1);
                    if ($urandom_range(0, 3) == 0) s = int'(I_selD);
                    I_sel[p*AW +: AW] = AW'(s);
                end
            end
            #1;
            for (int p = 0; p < NR; p++) begin
                exp = exp_read(int'(I_sel[p*AW +: AW]), 1'b0);
                vectors++;
                if (O_data[p*DW +: DW] !== exp) begin
                    miscompares++;
                    $display("FAIL wr_rd it%0d p%0d sel=%0d: got %h, expected %h", it, p, I_sel[p*AW +: AW], O_data[p*DW +: DW], exp);
                end
                exp = exp_read(int'(I_sel[p*AW +: AW]), 1'b1);
                vectors++;
                if (O_data_z[p*DW +: DW] !== exp) begin
                    miscompares++;
                    $display("FAIL wr_rd_z it%0d p%0d sel=%0d: got %h, expected %h", it, p, I_sel[p*AW +: AW], O_data_z[p*DW +: DW], exp);
                end
            end
            step();
        end
        I_we = 1'b0;
    endtask

    task automatic test_r0();
        logic [DW-1:0] exp;
        for (int k = 0; k < 2; k++) begin
            I_we = (k == 0); I_selD = 5'd0; I_dataD = 32'hFFFFFFFF; set_sel(0, 0);
            #1;
            for (int p = 0; p < NR; p++) begin
                exp = exp_read(0, 1'b0);
                vectors++;
                if (O_data[p*DW +: DW] !== exp) begin
                    miscompares++;
                    $display("FAIL r0_plain k%0d p%0d: got %h, expected %h", k, p, O_data[p*DW +: DW], exp);
                end
                vectors++;
                if (O_data_z[p*DW +: DW] !== 32'h0) begin
                    miscompares++;
                    $display("FAIL r0_zero k%0d p%0d: got %h, expected 00000000", k, p, O_data_z[p*DW +: DW]);
                end
            end
            step();
        end
        I_we = 1'b0;
    endtask

    task automatic test_clear();
        int n;
        logic [DW-1:0] exp;
        I_we = 1'b1; I_selD = 5'd7; I_dataD = 32'h00000ABC; I_clear = 1'b1; set_sel(7, 9);
        #1;
        for (int p = 0; p < NR; p++) begin
            exp = exp_read(int'(I_sel[p*AW +: AW]), 1'b0);
            vectors++;
            if (O_data[p*DW +: DW] !== exp) begin
                miscompares++;
                $display("FAIL clear_edge_rd p%0d: got %h, expected %h", p, O_data[p*DW +: DW], exp);
            end
        end
        step();
        // Init in progress: hold a write to r9 and keep clear asserted briefly; both must be ignored.
        I_selD = 5'd9; I_dataD = 32'h00000055;
        vectors++;
        if (O_ready !== 1'b0 || O_data !== '0) begin
            miscompares++;
            $display("FAIL clear_enter_init: got ready=%b data=%h, expected 0/0", O_ready, O_data);
        end
        n = 0;
        while (O_ready !== 1'b1 && n < 64) begin
            if (n == 5) I_clear = 1'b0;
            step(); n++;
        end
        I_clear = 1'b0;
        I_we = 1'b0;
        vectors++;
        if (n != 32) begin
            miscompares++;
            $display("FAIL clear_init_len: got %0d cycles, expected 32", n);
        end
        model_init();
        for (int k = 0; k < 2; k++) begin
            if (k == 1) set_sel(18, 0);
            #1;
            for (int p = 0; p < NR; p++) begin
                exp = exp_read(int'(I_sel[p*AW +: AW]), 1'b0);
                vectors++;
                if (O_data[p*DW +: DW] !== exp) begin
                    miscompares++;
                    $display("FAIL clear_contents p%0d sel=%0d: got %h, expected %h", p, I_sel[p*AW +: AW], O_data[p*DW +: DW], exp);
                end
            end
        end
    endtask

    task automatic test_reset_mid_init();
        int n;
        logic [DW-1:0] exp;
        I_we = 1'b1; I_selD = 5'd4; I_dataD = 32'h0BADF00D;
        step();
        I_we = 1'b0;
        I_rst = 1'b0; model_ready = 1'b0;
        step();
        I_rst = 1'b1;
        for (int i = 0; i < 10; i++) step();
        I_rst = 1'b0;
        #1;
        vectors++;
        if (O_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_init_ready: got %b, expected 0", O_ready);
        end
        step();
        I_rst = 1'b1;
        n = 0;
        while (O_ready !== 1'b1 && n < 64) begin step(); n++; end
        vectors++;
        if (n != 32) begin
            miscompares++;
            $display("FAIL mid_init_len: got %0d cycles, expected 32", n);
        end
        model_init();
        set_sel(4, 18);
        #1;
        for (int p = 0; p < NR; p++) begin
            exp = exp_read(int'(I_sel[p*AW +: AW]), 1'b0);
            vectors++;
            if (O_data[p*DW +: DW] !== exp) begin
                miscompares++;
                $display("FAIL mid_init_contents p%0d: got %h, expected %h", p, O_data[p*DW +: DW], exp);
            end
        end
    endtask

    initial begin
        I_rst = 1'b0; I_we = 1'b0; I_clear = 1'b0; I_selD = '0; I_dataD = '0; I_sel = '0;
        test_reset();
        test_write_read();
        test_r0();
        test_clear();
        test_write_read();
        test_reset_mid_init();
        test_r0();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
